// File: rtl/ram_port_arbiter_if.sv
// Bundle between two requesting masters, the arbiter and one RAM port.
// The arbiter uses the slave view; the driving side uses the master view.
interface ram_port_arbiter_if;
  logic        m0_req_i, m1_req_i;
  logic        m0_we_i, m1_we_i;
  logic [31:0] m0_addr_bi, m1_addr_bi;
  logic [31:0] m0_wdata_bi, m1_wdata_bi;
  logic [3:0]  m0_be_bi, m1_be_bi;
  logic        m0_ack_o, m1_ack_o;
  logic        m0_resp_o, m1_resp_o;
  logic [31:0] m0_rdata_bo, m1_rdata_bo;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_bo, s_wdata_bo;
  logic [3:0]  s_be_bo;
  logic        s_ack_i, s_resp_i;
  logic [31:0] s_rdata_bi;

  modport slave (
    input  m0_req_i, m1_req_i, m0_we_i, m1_we_i,
    input  m0_addr_bi, m1_addr_bi,
    input  m0_wdata_bi, m1_wdata_bi,
    input  m0_be_bi, m1_be_bi,
    output m0_ack_o, m1_ack_o,
    output m0_resp_o, m1_resp_o,
    output m0_rdata_bo, m1_rdata_bo,
    output s_req_o, s_we_o, s_addr_bo,
    output s_wdata_bo, s_be_bo,
    input  s_ack_i, s_resp_i, s_rdata_bi
  );

  modport master (
    output m0_req_i, m1_req_i, m0_we_i, m1_we_i,
    output m0_addr_bi, m1_addr_bi,
    output m0_wdata_bi, m1_wdata_bi,
    output m0_be_bi, m1_be_bi,
    input  m0_ack_o, m1_ack_o,
    input  m0_resp_o, m1_resp_o,
    input  m0_rdata_bo, m1_rdata_bo,
    input  s_req_o, s_we_o, s_addr_bo,
    input  s_wdata_bo, s_be_bo,
    output s_ack_i, s_resp_i, s_rdata_bi
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for one RAM port with a single outstanding-read slot.
// Define RAM_PORT_ARBITER_PARITY_EN to add response error capture.
module ram_port_arbiter #(
  parameter string       FIXED_PRIO = "NO",
  parameter int unsigned RR_INIT    = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  ram_port_arbiter_if.slave bus
`ifdef RAM_PORT_ARBITER_PARITY_EN
  ,
  input  logic        s_irq_i,
  input  logic        err_clr_i,
  output logic        err_valid_o,
  output logic        err_master_o,
  output logic [31:0] err_addr_bo,
  output logic [7:0]  err_cnt_bo
`endif
);

  localparam bit FIXED = (FIXED_PRIO == "YES");
  localparam bit RR0   = (RR_INIT != 0);

  logic prio_q, prio_d;
  logic pend_vld_q, pend_vld_d;
  logic pend_id_q, pend_id_d;
  logic gnt_vld, gnt_id, prio_eff;
  logic sel_we, acc_rd, resp_ok;

  always_comb begin
    prio_eff = FIXED ? 1'b0 : prio_q;
    gnt_vld  = bus.m0_req_i | bus.m1_req_i;
    gnt_id   = (bus.m0_req_i & bus.m1_req_i)
             ? prio_eff : bus.m1_req_i;
  end

  always_comb begin
    bus.s_req_o    = 1'b0;
    bus.s_we_o     = 1'b0;
    bus.s_addr_bo  = '0;
    bus.s_wdata_bo = '0;
    bus.s_be_bo    = '0;
    sel_we         = 1'b0;
    if (gnt_vld && !gnt_id) begin
      sel_we         = bus.m0_we_i;
      bus.s_req_o    = 1'b1;
      bus.s_we_o     = bus.m0_we_i;
      bus.s_addr_bo  = bus.m0_addr_bi;
      bus.s_wdata_bo = bus.m0_wdata_bi;
      bus.s_be_bo    = bus.m0_be_bi;
    end else if (gnt_vld) begin
      sel_we         = bus.m1_we_i;
      bus.s_req_o    = 1'b1;
      bus.s_we_o     = bus.m1_we_i;
      bus.s_addr_bo  = bus.m1_addr_bi;
      bus.s_wdata_bo = bus.m1_wdata_bi;
      bus.s_be_bo    = bus.m1_be_bi;
    end
  end

  always_comb begin
    bus.m0_ack_o    = bus.s_ack_i & gnt_vld & ~gnt_id;
    bus.m1_ack_o    = bus.s_ack_i & gnt_vld & gnt_id;
    acc_rd          = bus.s_ack_i & gnt_vld & ~sel_we;
    // a response landing while reset is high is dropped
    resp_ok         = bus.s_resp_i & pend_vld_q & ~rst_i;
    bus.m0_resp_o   = resp_ok & ~pend_id_q;
    bus.m1_resp_o   = resp_ok & pend_id_q;
    bus.m0_rdata_bo = bus.s_rdata_bi;
    bus.m1_rdata_bo = bus.s_rdata_bi;
  end

  always_comb begin
    prio_d     = bus.s_ack_i ? ~prio_q : prio_q;
    pend_vld_d = pend_vld_q;
    pend_id_d  = pend_id_q;
    if (acc_rd) begin
      pend_vld_d = 1'b1;
      pend_id_d  = gnt_id;
    end else if (bus.s_resp_i) begin
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q     <= RR0;
      pend_vld_q <= 1'b0;
      pend_id_q  <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      pend_vld_q <= pend_vld_d;
      pend_id_q  <= pend_id_d;
    end
  end

`ifdef RAM_PORT_ARBITER_PARITY_EN
  logic [31:0] pend_addr_q, pend_addr_d;
  logic        err_vld_q, err_vld_d;
  logic        err_mst_q, err_mst_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        err_hit;

  always_comb begin
    pend_addr_d = acc_rd ? bus.s_addr_bo : pend_addr_q;
    err_hit     = bus.s_resp_i & pend_vld_q & s_irq_i;
    err_vld_d   = err_vld_q;
    err_mst_d   = err_mst_q;
    err_addr_d  = err_addr_q;
    err_cnt_d   = err_cnt_q;
    if (err_hit) begin
      // a clear in the same cycle restarts from this error
      if (err_clr_i)
        err_cnt_d = 8'd1;
      else if (err_cnt_q != 8'hFF)
        err_cnt_d = err_cnt_q + 8'd1;
      if (!err_vld_q || err_clr_i) begin
        err_vld_d  = 1'b1;
        err_mst_d  = pend_id_q;
        err_addr_d = pend_addr_q;
      end
    end else if (err_clr_i) begin
      err_vld_d = 1'b0;
      err_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_addr_q <= '0;
      err_vld_q   <= 1'b0;
      err_mst_q   <= 1'b0;
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      pend_addr_q <= pend_addr_d;
      err_vld_q   <= err_vld_d;
      err_mst_q   <= err_mst_d;
      err_addr_q  <= err_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign err_valid_o  = err_vld_q;
  assign err_master_o = err_mst_q;
  assign err_addr_bo  = err_addr_q;
  assign err_cnt_bo   = err_cnt_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: round-robin and fixed-priority
// instances, read response routing, reset behaviour, optional error capture.
module tb_ram_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ram_port_arbiter_if bus ();
  ram_port_arbiter_if bus2 ();

`ifdef RAM_PORT_ARBITER_PARITY_EN
  logic        irq, clr, e_vld, e_mst;
  logic [31:0] e_addr;
  logic [7:0]  e_cnt;
  logic        irq2, clr2, e_vld2, e_mst2;
  logic [31:0] e_addr2;
  logic [7:0]  e_cnt2;
`endif

  ram_port_arbiter #(.FIXED_PRIO("NO"), .RR_INIT(0)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
`ifdef RAM_PORT_ARBITER_PARITY_EN
    ,
    .s_irq_i(irq),
    .err_clr_i(clr),
    .err_valid_o(e_vld),
    .err_master_o(e_mst),
    .err_addr_bo(e_addr),
    .err_cnt_bo(e_cnt)
`endif
  );

  ram_port_arbiter #(.FIXED_PRIO("YES"), .RR_INIT(1)) dut_fix (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus2)
`ifdef RAM_PORT_ARBITER_PARITY_EN
    ,
    .s_irq_i(irq2),
    .err_clr_i(clr2),
    .err_valid_o(e_vld2),
    .err_master_o(e_mst2),
    .err_addr_bo(e_addr2),
    .err_cnt_bo(e_cnt2)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.m0_req_i = 0; bus.m1_req_i = 0;
    bus.m0_we_i = 0;  bus.m1_we_i = 0;
    bus.m0_addr_bi = 32'h100; bus.m1_addr_bi = 32'h200;
    bus.m0_wdata_bi = 32'hA0A0; bus.m1_wdata_bi = 32'hB1B1;
    bus.m0_be_bi = 4'hF; bus.m1_be_bi = 4'h3;
    bus.s_ack_i = 0; bus.s_resp_i = 0;
    bus.s_rdata_bi = 32'h0;
`ifdef RAM_PORT_ARBITER_PARITY_EN
    irq = 0; clr = 0;
`endif
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    bus2.m0_req_i = 0; bus2.m1_req_i = 0;
    bus2.m0_we_i = 1; bus2.m1_we_i = 1;
    bus2.m0_addr_bi = 32'h11; bus2.m1_addr_bi = 32'h22;
    bus2.m0_wdata_bi = 0; bus2.m1_wdata_bi = 0;
    bus2.m0_be_bi = 0; bus2.m1_be_bi = 0;
    bus2.s_ack_i = 0; bus2.s_resp_i = 0;
    bus2.s_rdata_bi = 0;
`ifdef RAM_PORT_ARBITER_PARITY_EN
    irq2 = 0; clr2 = 0;
`endif
    do_reset();

    // no grant: all downstream outputs zero
    #1;
    chk("idle_req", bus.s_req_o, 0);
    chk("idle_addr", bus.s_addr_bo, 0);
    chk("idle_wdata", bus.s_wdata_bo, 0);
    chk("idle_be", bus.s_be_bo, 0);
    // stray response after reset: nothing pending
    bus.s_resp_i = 1;
    #1;
    chk("stray_r0", bus.m0_resp_o, 0);
    chk("stray_r1", bus.m1_resp_o, 0);
    tick();

    // single m0 read at 0x10, response next cycle
    idle();
    bus.m0_req_i = 1; bus.m0_addr_bi = 32'h10;
    bus.s_ack_i = 1;
    #1;
    chk("rd_req", bus.s_req_o, 1);
    chk("rd_addr", bus.s_addr_bo, 32'h10);
    chk("rd_we", bus.s_we_o, 0);
    chk("rd_ack0", bus.m0_ack_o, 1);
    chk("rd_ack1", bus.m1_ack_o, 0);
    tick();
    idle();
    bus.s_resp_i = 1; bus.s_rdata_bi = 32'hDEADBEEF;
    #1;
    chk("rd_resp0", bus.m0_resp_o, 1);
    chk("rd_resp1", bus.m1_resp_o, 0);
    chk("rd_data0", bus.m0_rdata_bo, 32'hDEADBEEF);
    chk("rd_data1", bus.m1_rdata_bo, 32'hDEADBEEF);
    tick();

    // round robin, both write continuously, always acked
    do_reset();
    bus.m0_req_i = 1; bus.m1_req_i = 1;
    bus.m0_we_i = 1; bus.m1_we_i = 1;
    bus.s_ack_i = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ack0", bus.m0_ack_o, (k % 2) == 0);
      chk("rr_ack1", bus.m1_ack_o, (k % 2) == 1);
      chk("rr_addr", bus.s_addr_bo,
          (k % 2) == 0 ? 32'h100 : 32'h200);
      tick();
    end
    // writes leave no pending read
    idle();
    bus.s_resp_i = 1;
    #1;
    chk("wr_noresp0", bus.m0_resp_o, 0);
    chk("wr_noresp1", bus.m1_resp_o, 0);
    tick();

    // stall: grant holds through 3 unacked cycles
    idle();
    bus.m0_req_i = 1; bus.m1_req_i = 1;
    bus.m0_we_i = 1; bus.m1_we_i = 1;
    for (int k = 0; k < 4; k++) begin
      bus.s_ack_i = (k == 3);
      #1;
      chk("stall_addr", bus.s_addr_bo, 32'h100);
      chk("stall_ack0", bus.m0_ack_o, k == 3);
      tick();
    end
    bus.s_ack_i = 0;
    #1;
    chk("stall_flip", bus.s_addr_bo, 32'h200);
    tick();

    // back-to-back reads m0@0x4, m1@0x8
    do_reset();
    bus.m0_req_i = 1; bus.m0_addr_bi = 32'h4;
    bus.s_ack_i = 1;
    #1;
    chk("b2b_ack0", bus.m0_ack_o, 1);
    tick();
    idle();
    bus.m1_req_i = 1; bus.m1_addr_bi = 32'h8;
    bus.s_ack_i = 1;
    bus.s_resp_i = 1; bus.s_rdata_bi = 32'h1111;
    #1;
    chk("b2b_ack1", bus.m1_ack_o, 1);
    chk("b2b_r0a", bus.m0_resp_o, 1);
    chk("b2b_r1a", bus.m1_resp_o, 0);
    chk("b2b_d0", bus.m0_rdata_bo, 32'h1111);
    tick();
    idle();
    bus.s_resp_i = 1; bus.s_rdata_bi = 32'h2222;
    #1;
    chk("b2b_r0b", bus.m0_resp_o, 0);
    chk("b2b_r1b", bus.m1_resp_o, 1);
    chk("b2b_d1", bus.m1_rdata_bo, 32'h2222);
    tick();
    #1;
    chk("b2b_done0", bus.m0_resp_o, 0);
    chk("b2b_done1", bus.m1_resp_o, 0);
    tick();

    // reset in the response cycle drops the response
    do_reset();
    bus.m1_req_i = 1; bus.s_ack_i = 1;
    #1;
    chk("rstr_ack1", bus.m1_ack_o, 1);
    tick();
    idle();
    rst = 1;
    bus.s_resp_i = 1;
    #1;
    chk("rstr_r0", bus.m0_resp_o, 0);
    chk("rstr_r1", bus.m1_resp_o, 0);
    tick();
    rst = 0;
    bus.m0_req_i = 1; bus.m1_req_i = 1;
    bus.s_resp_i = 1;
    #1;
    chk("rstr_prio", bus.s_addr_bo, 32'h100);
    chk("rstr_none", bus.m1_resp_o, 0);
    tick();

    // fixed priority: m0 always wins despite RR_INIT=1
    idle();
    bus2.m0_req_i = 1; bus2.m1_req_i = 1;
    bus2.s_ack_i = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fix_ack0", bus2.m0_ack_o, 1);
      chk("fix_ack1", bus2.m1_ack_o, 0);
      tick();
    end
    bus2.m0_req_i = 0;
    #1;
    chk("fix_only1", bus2.m1_ack_o, 1);
    bus2.m1_req_i = 0; bus2.s_ack_i = 0;
    tick();

`ifdef RAM_PORT_ARBITER_PARITY_EN
    // error capture holds the first error, counts both
    do_reset();
    bus.m1_req_i = 1; bus.m1_addr_bi = 32'h20;
    bus.s_ack_i = 1;
    tick();
    idle();
    bus.s_resp_i = 1; irq = 1;
    tick();
    idle();
    bus.m0_req_i = 1; bus.m0_addr_bi = 32'h30;
    bus.s_ack_i = 1;
    tick();
    idle();
    bus.s_resp_i = 1; irq = 1;
    tick();
    idle();
    chk("err_vld", e_vld, 1);
    chk("err_mst", e_mst, 1);
    chk("err_addr", e_addr, 32'h20);
    chk("err_cnt", e_cnt, 2);
    clr = 1;
    tick();
    clr = 0;
    chk("clr_vld", e_vld, 0);
    chk("clr_cnt", e_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default "NO", meaning "YES" gives master 0 strict priority and "NO" gives round-robin.
REQ-002 SHALL have parameter RR_INIT, default 0, meaning the master that holds priority after reset.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports m0_req_i/m1_req_i, m0_we_i/m1_we_i, inputs, 1 each: master request and write enable.
REQ-006 SHALL have ports m0_addr_bi/m1_addr_bi and m0_wdata_bi/m1_wdata_bi, inputs, 32 each, plus m0_be_bi/m1_be_bi, inputs, 4 each: master address, write data and byte enables.
REQ-007 SHALL have ports m0_ack_o/m1_ack_o and m0_resp_o/m1_resp_o, outputs, 1 each, plus m0_rdata_bo/m1_rdata_bo, outputs, 32 each: master accept, read response and read data.
REQ-008 SHALL have ports s_req_o, s_we_o (outputs, 1), s_addr_bo, s_wdata_bo (outputs, 32) and s_be_bo (output, 4): the downstream RAM port request.
REQ-009 SHALL have ports s_ack_i, s_resp_i (inputs, 1) and s_rdata_bi (input, 32): the downstream RAM port accept, response and data.

Function
REQ-010 SHALL select a grant combinationally each cycle: only one master requesting -> that master; both requesting -> the priority master; neither -> s_req_o=0.
REQ-011 SHALL drive s_req_o, s_we_o, s_addr_bo, s_be_bo and s_wdata_bo combinationally from the granted master; with no grant, all s_* outputs SHALL be 0.
REQ-012 SHALL drive mN_ack_o = s_ack_i AND (grant==N); the non-granted master's ack SHALL be 0.
REQ-013 In round-robin mode, the priority SHALL move to the other master on every cycle in which s_ack_i=1, and SHALL stay unchanged when s_ack_i=0, so a stalled request keeps its grant.
REQ-014 In FIXED_PRIO="YES" mode, master 0 SHALL always win contention and RR_INIT SHALL be ignored.
REQ-015 On an accepted read (s_ack_i=1 and s_we_o=0), SHALL register the granted master id and s_addr_bo into a pending slot and set pending_valid.
REQ-016 When s_resp_i=1, SHALL assert mN_resp_o for exactly that cycle, where N is the pending id, and SHALL clear pending_valid unless a new read is accepted in the same cycle.
REQ-017 An accepted read and a response in the same cycle SHALL both take effect: the response uses the old id, and the slot loads the new id.
REQ-018 SHALL drive both mN_rdata_bo outputs from s_rdata_bi unconditionally; masters qualify the data with resp.
REQ-019 If s_resp_i=1 while pending_valid=0, SHALL assert no mN_resp_o.
REQ-020 Writes SHALL produce no response and SHALL not touch the pending slot.

Reset
REQ-021 On rst_i=1 at a clock edge: pending_valid=0, priority=RR_INIT, and all error state cleared.
REQ-022 Since mN_resp_o are 0 when pending_valid=0, the first cycle after reset SHALL show no response.
REQ-023 A response arriving in the cycle rst_i is high SHALL be dropped.

Configuration
REQ-024 Macro RAM_PORT_ARBITER_PARITY_EN, when defined, SHALL add ports s_irq_i (input, 1), err_clr_i (input, 1), err_valid_o (output, 1), err_master_o (output, 1), err_addr_bo (output, 32) and err_cnt_bo (output, 8).
REQ-025 With the macro defined, a cycle with s_resp_i=1, pending_valid=1 and s_irq_i=1 SHALL increment err_cnt_bo, saturating at 255.
REQ-026 With the macro defined, if err_valid_o=0 in that cycle, SHALL also capture the pending address and id into err_addr_bo/err_master_o and set err_valid_o; if err_valid_o=1, the first captured error SHALL be held.
REQ-027 err_clr_i=1 SHALL clear err_valid_o and err_cnt_bo; an error in the same cycle SHALL win, leaving err_valid_o=1, the new capture and err_cnt_bo=1.
REQ-028 Without the macro, these ports and this logic SHALL be absent, and s_irq_i behaviour SHALL not exist.

Verification
REQ-029 Only m0 issues a read at 0x10, with s_ack_i=1 and s_resp_i=1 one cycle later, rdata=0xDEADBEEF -> m0_ack_o=1, then next cycle m0_resp_o=1, m1_resp_o=0, m0_rdata_bo=0xDEADBEEF.
REQ-030 Round-robin, RR_INIT=0, both masters requesting continuously, s_ack_i always 1 -> grants m0,m1,m0,m1 on consecutive cycles.
REQ-031 Both masters requesting, s_ack_i=0 for 3 cycles then 1 -> the grant stays on the same master for all 4 cycles, and priority flips only after the ack.
REQ-032 Back-to-back reads m0 at 0x4 then m1 at 0x8, each response one cycle after its ack -> m0_resp_o then m1_resp_o on consecutive cycles, each with the correct data.
REQ-033 Read in flight, then rst_i asserted in the response cycle -> no mN_resp_o, and priority=RR_INIT.
REQ-034 With PARITY_EN defined, m1 reads 0x20 with s_irq_i=1 at response, then m0 errors at 0x30 -> err_valid_o=1, err_master_o=1, err_addr_bo=0x20, err_cnt_bo=2; then err_clr_i -> err_valid_o=0, err_cnt_bo=0.
